// File: rtl/rtc_bank_reader.sv
// rtc_bank_reader
//   Read side of the programming register bank. A start pulse begins a sweep
//   over bank addresses 0..NUM_REGS-1. The block reads each byte and hands it
//   to the RTC driver over a 4-phase req/ack handshake. During a sweep the bank
//   write-enable mux is switched to the RTC path, so button writes cannot
//   disturb the registers being copied. The mux returns to the button path
//   when the block goes idle.
//
// Ports
//   clk        in   system clock; all logic runs on the rising edge
//   reset      in   synchronous, active-high
//   start      in   one-cycle pulse that begins a sweep; honoured only in IDLE
//   bank_addr  out  bank read address
//   bank_rd    out  bank read strobe; data is valid one cycle after it
//   bank_dout  in   bank read data
//   wr_sel     out  write-enable mux select: 1 = button path, 0 = RTC path
//   rtc_req    out  handshake request
//   rtc_addr   out  RTC register address, stable while rtc_req is high
//   rtc_data   out  RTC data byte, stable while rtc_req is high
//   rtc_ack    in   handshake acknowledge from the RTC driver
//   busy       out  high from start acceptance until the return to IDLE
//   done       out  one-cycle pulse when a sweep completes normally
//   error      out  one-cycle pulse when a sweep is aborted on an ack timeout
//
// All outputs come directly from flops.
module rtc_bank_reader #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 4,
  parameter int                NUM_REGS = 9,
  parameter logic [ADDR_W-1:0] RTC_BASE = ADDR_W'(1),
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] bank_addr,
  output logic              bank_rd,
  input  logic [DATA_W-1:0] bank_dout,
  output logic              wr_sel,
  output logic              rtc_req,
  output logic [ADDR_W-1:0] rtc_addr,
  output logic [DATA_W-1:0] rtc_data,
  input  logic              rtc_ack,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // The wait counter never has to hold TIMEOUT itself: the abort fires on
  // the cycle in which the count would reach TIMEOUT.
  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_REQ_HI,
    S_REQ_LO,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] bank_addr_q, bank_addr_d;
  logic              bank_rd_q, bank_rd_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rtc_req_q, rtc_req_d;
  logic [ADDR_W-1:0] rtc_addr_q, rtc_addr_d;
  logic [DATA_W-1:0] rtc_data_q, rtc_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              timeout_hit;
  logic              abort;
  logic              waiting;

  // The counter reaches TIMEOUT if the current wait cycle also fails.
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign waiting     = (state_q == S_REQ_HI) || (state_q == S_REQ_LO);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      bank_addr_q <= '0;
      bank_rd_q   <= 1'b0;
      wr_sel_q    <= 1'b1;
      rtc_req_q   <= 1'b0;
      rtc_addr_q  <= '0;
      rtc_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      bank_addr_q <= bank_addr_d;
      bank_rd_q   <= bank_rd_d;
      wr_sel_q    <= wr_sel_d;
      rtc_req_q   <= rtc_req_d;
      rtc_addr_q  <= rtc_addr_d;
      rtc_data_q  <= rtc_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: state, index, and wait counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abort   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          idx_d   = '0;
        end
      end

      S_READ: state_d = S_LATCH;

      S_LATCH: state_d = S_REQ_HI;

      // Leave only after our own request has been acknowledged. An ack that
      // is already high before the request rises keeps us here.
      S_REQ_HI: begin
        if (rtc_req_q && rtc_ack) begin
          state_d = S_REQ_LO;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end

      S_REQ_LO: begin
        if (!rtc_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // An aborted sweep keeps no position. The next start begins at index 0.
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end

    // The counter restarts on every state change and runs only while waiting
    // on an ack edge.
    cnt_d = '0;
    if ((state_d == state_q) && waiting) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: each registered output takes the value it must show in the
  // state being entered.
  // ---------------------------------------------------------------------------
  always_comb begin
    bank_rd_d   = (state_d == S_READ);
    bank_addr_d = (state_d == S_READ) ? idx_d : bank_addr_q;

    // Address and data are captured one cycle after the read strobe. They
    // then stay frozen through the whole handshake.
    rtc_addr_d  = rtc_addr_q;
    rtc_data_d  = rtc_data_q;
    if (state_q == S_LATCH) begin
      rtc_addr_d = RTC_BASE + idx_q;
      rtc_data_d = bank_dout;
    end

    // The request rises only while ack is low. Once up, it stays up until
    // the ack is seen, or until an abort moves the state away from S_REQ_HI.
    rtc_req_d = (state_d == S_REQ_HI) && (rtc_req_q || !rtc_ack);

    busy_d   = (state_d == S_READ)   || (state_d == S_LATCH) ||
               (state_d == S_REQ_HI) || (state_d == S_REQ_LO);
    // The mux stays on the RTC path for exactly the busy window.
    wr_sel_d = !busy_d;
    done_d   = (state_d == S_FINISH);
    error_d  = abort;
  end

  assign bank_addr = bank_addr_q;
  assign bank_rd   = bank_rd_q;
  assign wr_sel    = wr_sel_q;
  assign rtc_req   = rtc_req_q;
  assign rtc_addr  = rtc_addr_q;
  assign rtc_data  = rtc_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_rtc_bank_reader.sv
// Testbench for rtc_bank_reader.
//   Instance A uses the default parameters. Instance B uses RTC_BASE=C and
//   NUM_REGS=6 to exercise address wrap-around.
//   A table of sweep scenarios is applied in a loop. Hand-written sequences
//   cover reset in mid-sweep and the wrap case.
//   Expected transfers are queued when start is driven. They are popped and
//   compared when the RTC responder acknowledges a request.
module tb_rtc_bank_reader;

  localparam int TIMEOUT = 255;
  localparam logic [21:0] RESET_VEC = {4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] bank_addr;
  logic       bank_rd;
  logic [7:0] bank_dout = 8'hA5;
  logic       wr_sel;
  logic       rtc_req;
  logic [3:0] rtc_addr;
  logic [7:0] rtc_data;
  logic       rtc_ack = 1'b0;
  logic       busy, done, error;

  logic       b_start = 1'b0;
  logic [3:0] b_bank_addr;
  logic       b_bank_rd;
  logic [7:0] b_bank_dout = 8'hA5;
  logic       b_wr_sel;
  logic       b_req;
  logic [3:0] b_addr;
  logic [7:0] b_data;
  logic       b_ack = 1'b0;
  logic       b_busy, b_done, b_error;

  always #5 clk = ~clk;

  rtc_bank_reader u_dut (
    .clk(clk), .reset(reset), .start(start),
    .bank_addr(bank_addr), .bank_rd(bank_rd), .bank_dout(bank_dout),
    .wr_sel(wr_sel), .rtc_req(rtc_req), .rtc_addr(rtc_addr), .rtc_data(rtc_data),
    .rtc_ack(rtc_ack), .busy(busy), .done(done), .error(error)
  );

  rtc_bank_reader #(.RTC_BASE(4'hC), .NUM_REGS(6)) u_dut_wrap (
    .clk(clk), .reset(reset), .start(b_start),
    .bank_addr(b_bank_addr), .bank_rd(b_bank_rd), .bank_dout(b_bank_dout),
    .wr_sel(b_wr_sel), .rtc_req(b_req), .rtc_addr(b_addr), .rtc_data(b_data),
    .rtc_ack(b_ack), .busy(b_busy), .done(b_done), .error(b_error)
  );

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } xfer_t;

  typedef struct {
    int ack_delay;       // negedges the responder waits before each ack edge
    int ack_mode;        // 0 normal, 1 never ack, 2 ack held high at start
    int data_base;       // bank[i] = data_base + i
    int restart_at;      // pulse start again once this many transfers are done (-1 none)
    int finish_restart;  // pulse start during the done cycle
    int exp_xfers;
    int exp_done;
    int exp_error;
    int exp_lat;         // start-to-req latency in cycles (0 = not checked)
  } case_t;

  int tests = 0;
  int fails = 0;

  xfer_t exp_q[$];
  xfer_t b_q[$];
  logic [7:0] bank_mem [16];

  logic       a_rd_pend = 1'b0, b_rd_pend = 1'b0;
  logic [3:0] a_rd_addr = '0, b_rd_addr = '0;
  logic       req_prev = 1'b0;

  int ack_delay = 2;
  int ack_mode = 0;
  int ack_cnt = 0;
  int xfers, done_cnt, err_cnt, wrsel_viol, rise_viol, req_hi_cycles;
  int first_req, sweep_cyc;
  int b_xfers, b_done_cnt, b_err_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] out_vec();
    return {bank_addr, bank_rd, wr_sel, rtc_req, rtc_addr, rtc_data, busy, done, error};
  endfunction

  // One clock cycle. It advances to the falling edge and updates the bank
  // models, the monitors and the RTC responders, all from this process.
  task automatic tick();
    xfer_t e;
    @(negedge clk);
    // Bank models: data appears one cycle after the strobe and is garbage
    // otherwise.
    bank_dout   = a_rd_pend ? bank_mem[a_rd_addr] : 8'hA5;
    a_rd_pend   = bank_rd;
    a_rd_addr   = bank_addr;
    b_bank_dout = b_rd_pend ? bank_mem[b_rd_addr] : 8'hA5;
    b_rd_pend   = b_bank_rd;
    b_rd_addr   = b_bank_addr;

    if (reset) begin
      rtc_ack = 1'b0;
      ack_cnt = 0;
      b_ack   = 1'b0;
    end else begin
      sweep_cyc++;
      if (done)  done_cnt++;
      if (error) err_cnt++;
      if (wr_sel == busy) wrsel_viol++;
      if (rtc_req && !req_prev && rtc_ack) rise_viol++;
      if (rtc_req) req_hi_cycles++;
      if (rtc_req && first_req == 0) first_req = sweep_cyc;

      if (ack_mode == 0) begin
        if (rtc_req && !rtc_ack) begin
          if (ack_cnt >= ack_delay) begin
            if (exp_q.size() == 0) begin
              check("xfer_expected", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              check("xfer", {wr_sel, busy, rtc_addr, rtc_data}, {1'b0, 1'b1, e.addr, e.data});
            end
            $display("[TB] xfer addr=%h data=%h", rtc_addr, rtc_data);
            xfers++;
            rtc_ack = 1'b1;
            ack_cnt = 0;
          end else begin
            ack_cnt++;
          end
        end else if (!rtc_req && rtc_ack) begin
          if (ack_cnt >= ack_delay) begin
            rtc_ack = 1'b0;
            ack_cnt = 0;
          end else begin
            ack_cnt++;
          end
        end else begin
          ack_cnt = 0;
        end
      end

      if (b_done)  b_done_cnt++;
      if (b_error) b_err_cnt++;
      if (b_req && !b_ack) begin
        if (b_q.size() == 0) begin
          check("wrap_xfer_expected", b_q.size(), 1);
        end else begin
          e = b_q.pop_front();
          check("wrap_xfer", {b_addr, b_data}, {e.addr, e.data});
        end
        $display("[TB] wrap xfer addr=%h data=%h", b_addr, b_data);
        b_xfers++;
        b_ack = 1'b1;
      end else if (!b_req && b_ack) begin
        b_ack = 1'b0;
      end
    end
    req_prev = rtc_req;
  endtask

  task automatic clear_counts();
    xfers = 0; done_cnt = 0; err_cnt = 0; wrsel_viol = 0; rise_viol = 0;
    req_hi_cycles = 0; first_req = 0; sweep_cyc = 0;
  endtask

  task automatic run_case(input case_t c);
    int cyc;
    bit restarted;
    for (int i = 0; i < 16; i++) bank_mem[i] = 8'(c.data_base + i);
    ack_delay = c.ack_delay;
    ack_mode  = c.ack_mode;
    if (c.ack_mode == 2) rtc_ack = 1'b1;
    clear_counts();
    restarted = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back({4'(1 + i), 8'(c.data_base + i)});

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_accept", {busy, bank_rd, bank_addr, wr_sel}, {1'b1, 1'b1, 4'h0, 1'b0});

    cyc = 0;
    while (done_cnt + err_cnt == 0 && cyc < 3000) begin
      if (c.restart_at >= 0 && !restarted && xfers == c.restart_at && busy) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        restarted = 1'b1;
      end else if (ack_mode == 2 && sweep_cyc == 12) begin
        check("req_low_while_ack_high", req_hi_cycles, 0);
        rtc_ack  = 1'b0;
        ack_mode = 0;
        tick();
      end else begin
        tick();
      end
      cyc++;
    end
    check("sweep_ended", cyc < 3000, 1'b1);
    if (c.finish_restart != 0) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    repeat (3) tick();

    check("xfer_count", xfers, c.exp_xfers);
    check("done_pulses", done_cnt, c.exp_done);
    check("error_pulses", err_cnt, c.exp_error);
    check("wr_sel_vs_busy", wrsel_viol, 0);
    check("req_rise_with_ack", rise_viol, 0);
    check("idle_after_sweep", {busy, wr_sel, rtc_req}, {1'b0, 1'b1, 1'b0});
    if (c.exp_lat != 0) check("req_latency", first_req, c.exp_lat);
    if (c.exp_error != 0) check("timeout_req_cycles", req_hi_cycles, TIMEOUT);
    if (c.exp_done != 0) check("all_expected_seen", exp_q.size(), 0);
    exp_q.delete();
  endtask

  case_t cases [5];

  initial begin
    int cyc;
    cases[0] = '{2, 0, 'h10, -1, 0, 9, 1, 0, 3};  // plain sweep, 2-cycle responder
    cases[1] = '{1, 0, 'h40,  3, 0, 9, 1, 0, 3};  // start again during transfer 4
    cases[2] = '{0, 1, 'h20, -1, 0, 0, 0, 1, 3};  // ack never arrives -> timeout
    cases[3] = '{3, 2, 'h80, -1, 0, 9, 1, 0, 0};  // ack held high at sweep start
    cases[4] = '{0, 0, 'hF0, -1, 1, 9, 1, 0, 3};  // start during the done cycle

    for (int i = 0; i < 16; i++) bank_mem[i] = 8'(i);
    clear_counts();
    b_xfers = 0; b_done_cnt = 0; b_err_cnt = 0;

    reset = 1'b1;
    repeat (3) tick();
    check("reset_outputs", out_vec(), RESET_VEC);
    reset = 1'b0;
    tick();
    check("idle_after_reset", out_vec(), RESET_VEC);

    for (int k = 0; k < 5; k++) run_case(cases[k]);

    // Reset while the request for transfer 5 is high. The sweep is dropped,
    // no pulse follows, and the next sweep starts at index 0.
    for (int i = 0; i < 16; i++) bank_mem[i] = 8'(8'h10 + i);
    ack_delay = 2;
    ack_mode  = 0;
    clear_counts();
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back({4'(1 + i), 8'(8'h10 + i)});
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(xfers == 4 && rtc_req && !rtc_ack) && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("reached_transfer_5", cyc < 2000, 1'b1);
    reset = 1'b1;
    tick();
    check("midsweep_reset_outputs", out_vec(), RESET_VEC);
    reset = 1'b0;
    exp_q.delete();
    repeat (4) tick();
    check("midsweep_no_pulse", done_cnt + err_cnt, 0);
    check("midsweep_idle", out_vec(), RESET_VEC);
    run_case(cases[0]);

    // Wrap-around instance: RTC addresses C, D, E, F, 0, 1.
    b_q.delete();
    for (int i = 0; i < 6; i++) b_q.push_back({4'(12 + i), bank_mem[i]});
    b_xfers = 0; b_done_cnt = 0; b_err_cnt = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cyc = 0;
    while (b_done_cnt == 0 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("wrap_sweep_ended", cyc < 2000, 1'b1);
    repeat (2) tick();
    check("wrap_xfer_count", b_xfers, 6);
    check("wrap_done_pulses", b_done_cnt, 1);
    check("wrap_error_pulses", b_err_cnt, 0);
    check("wrap_all_seen", b_q.size(), 0);
    check("wrap_idle", {b_busy, b_wr_sel, b_bank_rd, b_bank_addr != 4'h0}, {1'b0, 1'b1, 1'b0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
